// File: rtl/apb_txbuf_pingpong.sv
// APB-loaded ping-pong frame buffer that drains committed frames byte by byte over valid/ready.
// A flag register reports buffer state and holds a level interrupt raised after every drained frame.
module apb_txbuf_pingpong #(
  parameter int unsigned FRAME_LEN  = 224,
  parameter logic [31:0] FLAG_ADDR  = 32'h3000_0000,
  parameter logic [31:0] BUF_A_ADDR = 32'h3000_2000,
  parameter logic [31:0] BUF_B_ADDR = 32'h3000_4200
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [15:0] PWDATA,
  output logic [15:0] PRDATA,
  output logic        PREADY,
  output logic        INT,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        TX_LAST
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

  state_t        state, state_nxt;
  logic [7:0]    buf_a [FRAME_LEN];
  logic [7:0]    buf_b [FRAME_LEN];
  logic [IW-1:0] idx;
  logic          next_b;
  logic          a_empty, b_empty, a_full, b_full, int_pend;

  logic          wr_en, flag_hit, in_a, in_b, flag_wr;
  logic          commit_a, commit_b, done_a, done_b;
  logic          hs, hs_last;
  logic [31:0]   off_a, off_b;
  logic [15:0]   rd_data;
  logic          unused_pwdata;

  assign unused_pwdata = ^{PWDATA[15:13], PWDATA[11:9]};

  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign off_a    = PADDR - BUF_A_ADDR;
  assign off_b    = PADDR - BUF_B_ADDR;
  assign in_a     = off_a < 32'(FRAME_LEN);
  assign in_b     = off_b < 32'(FRAME_LEN);
  assign flag_hit = PADDR == FLAG_ADDR;
  assign flag_wr  = wr_en & flag_hit;

  // A buffer only accepts commits while empty, so a draining buffer cannot be recommitted
  assign commit_a = flag_wr & PWDATA[7] & a_empty;
  assign commit_b = flag_wr & PWDATA[8] & b_empty;
  assign done_a   = hs_last & (state == SEND_A);
  assign done_b   = hs_last & (state == SEND_B);

  assign PREADY = 1'b1;
  assign INT    = int_pend;

  // Buffer storage carries no reset so contents survive a mid-frame reset
  always_ff @(posedge Clk) begin
    if (wr_en && in_a && a_empty) buf_a[off_a[IW-1:0]] <= PWDATA[7:0];
    if (wr_en && in_b && b_empty) buf_b[off_b[IW-1:0]] <= PWDATA[7:0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    TX_VALID  = 1'b0;
    TX_DATA   = 8'h00;
    TX_LAST   = 1'b0;
    hs        = 1'b0;
    hs_last   = 1'b0;
    case (state)
      IDLE: begin
        if (!next_b && a_full)     state_nxt = SEND_A;
        else if (next_b && b_full) state_nxt = SEND_B;
      end
      SEND_A, SEND_B: begin
        TX_VALID = 1'b1;
        TX_DATA  = (state == SEND_A) ? buf_a[idx] : buf_b[idx];
        TX_LAST  = idx == LAST_IDX;
        hs       = TX_READY;
        hs_last  = TX_READY & (idx == LAST_IDX);
        if (hs_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx    <= '0;
      next_b <= 1'b0;
    end else if (hs_last) begin
      idx    <= '0;
      next_b <= ~next_b;
    end else if (hs) begin
      idx    <= idx + IW'(1);
    end
  end

  // Drain completion outranks a software clear of the interrupt in the same cycle
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_empty  <= 1'b1;
      b_empty  <= 1'b1;
      a_full   <= 1'b0;
      b_full   <= 1'b0;
      int_pend <= 1'b0;
    end else begin
      if (done_a) begin
        a_full  <= 1'b0;
        a_empty <= 1'b1;
      end else if (commit_a) begin
        a_full  <= 1'b1;
        a_empty <= 1'b0;
      end
      if (done_b) begin
        b_full  <= 1'b0;
        b_empty <= 1'b1;
      end else if (commit_b) begin
        b_full  <= 1'b1;
        b_empty <= 1'b0;
      end
      if (done_a || done_b)            int_pend <= 1'b1;
      else if (flag_wr && !PWDATA[12]) int_pend <= 1'b0;
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (flag_hit)  rd_data = {3'b000, int_pend, 3'b000, b_full, a_full, b_empty, a_empty, 5'b00000};
    else if (in_a) rd_data = {8'h00, buf_a[off_a[IW-1:0]]};
    else if (in_b) rd_data = {8'h00, buf_b[off_b[IW-1:0]]};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      PRDATA <= 16'h0000;
    else if (PSEL) PRDATA <= rd_data;
  end

endmodule

// File: tb/tb_apb_txbuf_pingpong.sv
// Directed bench for apb_txbuf_pingpong: APB loads with random data, drains with random backpressure.
// Expected frames come from byte arrays mirroring what software wrote, in ping-pong commit order.
module tb_apb_txbuf_pingpong;

  localparam int          FL   = 224;
  localparam logic [31:0] FLAG = 32'h3000_0000;
  localparam logic [31:0] BA   = 32'h3000_2000;
  localparam logic [31:0] BB   = 32'h3000_4200;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic        PREADY, INT;
  logic [7:0]  TX_DATA;
  logic        TX_VALID, TX_LAST;
  logic        TX_READY = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          stall_err = 0;
  logic [7:0]  mem_a [FL];
  logic [7:0]  mem_b [FL];
  logic [7:0]  exp_q [$];
  logic [8:0]  rx_q [$];

  always #5 Clk = ~Clk;

  apb_txbuf_pingpong dut (
    .Clk(Clk), .Rst(Rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .INT(INT),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_LAST(TX_LAST)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; reads need only PSEL and return PRDATA one cycle later
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [15:0] wdata,
                               output logic [15:0] rdata);
    @(negedge Clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge Clk);
    rdata = PRDATA;
    if (wr) begin
      PENABLE = 1'b1;
      @(negedge Clk);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic fillBuf(input bit is_b, input bit counting);
    @(negedge Clk);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    for (int i = 0; i < FL; i++) begin
      logic [7:0] d;
      d = counting ? 8'(i + 1) : 8'($urandom_range(0, 255));
      PADDR  = (is_b ? BB : BA) + 32'(i);
      PWDATA = {8'($urandom_range(0, 255)), d};
      if (is_b) mem_b[i] = d;
      else      mem_a[i] = d;
      @(negedge Clk);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic drain(input int n, input bit rnd, output int gaps);
    int         got = 0;
    int         budget = n * 8 + 200;
    bit         prev_stalled = 1'b0;
    logic [7:0] pd = '0;
    logic       pl = 1'b0;
    gaps = 0;
    rx_q.delete();
    while (got < n && budget > 0) begin
      @(negedge Clk);
      TX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stalled && (TX_VALID !== 1'b1 || TX_DATA !== pd || TX_LAST !== pl)) stall_err++;
      if (got > 0 && TX_VALID !== 1'b1) gaps++;
      prev_stalled = TX_VALID && !TX_READY;
      pd = TX_DATA;
      pl = TX_LAST;
      if (TX_VALID && TX_READY) begin
        rx_q.push_back({TX_LAST, TX_DATA});
        got++;
      end
      budget--;
    end
    checkOutput("handshakes", 32'(got), 32'(n));
    @(negedge Clk);
    TX_READY = 1'b0;
  endtask

  task automatic checkFrames(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= rx_q.size() || rx_q[i] !== {((i % FL) == FL - 1), exp_q[i]}) bad++;
    end
    checkOutput("frame_bytes_bad", 32'(bad), 32'd0);
    checkOutput("stall_unstable", 32'(stall_err), 32'd0);
  endtask

  task automatic expectBuf(input bit is_b);
    for (int i = 0; i < FL; i++) exp_q.push_back(is_b ? mem_b[i] : mem_a[i]);
  endtask

  initial begin
    logic [15:0] rd;
    int          gaps;

    #12;
    checkOutput("rst_prdata", 32'(PRDATA), 32'h0);
    checkOutput("rst_valid", 32'(TX_VALID), 32'h0);
    checkOutput("rst_pready", 32'(PREADY), 32'h1);
    checkOutput("rst_int", 32'(INT), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;

    applyStimulus(1'b0, FLAG, 16'h0, rd);
    checkOutput("flag_after_reset", 32'(rd), 32'h0060);

    fillBuf(1'b0, 1'b1);
    applyStimulus(1'b0, BA + 32'd223, 16'h0, rd);
    checkOutput("a_last_readback", 32'(rd), 32'h00E0);
    applyStimulus(1'b1, BA + 32'd230, 16'h0055, rd);
    applyStimulus(1'b0, BA + 32'd230, 16'h0, rd);
    checkOutput("a_idx230_unmapped", 32'(rd), 32'h0);

    applyStimulus(1'b1, FLAG, 16'h0080, rd);
    applyStimulus(1'b0, FLAG, 16'h0, rd);
    checkOutput("flag_a_committed", 32'(rd), 32'h00C0);
    applyStimulus(1'b1, BA + 32'd3, 16'h00AA, rd);
    checkOutput("stall_valid", 32'(TX_VALID), 32'h1);
    checkOutput("stall_first_byte", 32'(TX_DATA), 32'h01);

    exp_q.delete();
    expectBuf(1'b0);
    drain(FL, 1'b0, gaps);
    checkFrames(FL);
    checkOutput("int_after_frame", 32'(INT), 32'h1);
    applyStimulus(1'b0, FLAG, 16'h0, rd);
    checkOutput("flag_after_frame", 32'(rd), 32'h1060);
    applyStimulus(1'b1, FLAG, 16'h1000, rd);
    checkOutput("int_set_write_noop", 32'(INT), 32'h1);
    applyStimulus(1'b1, FLAG, 16'h0060, rd);
    checkOutput("int_cleared", 32'(INT), 32'h0);
    applyStimulus(1'b0, BA + 32'd3, 16'h0, rd);
    checkOutput("a_write_while_full", 32'(rd), 32'h0004);

    $display("[TB] buffer B with random backpressure");
    fillBuf(1'b1, 1'b0);
    applyStimulus(1'b1, FLAG, 16'h0100, rd);
    exp_q.delete();
    expectBuf(1'b1);
    drain(FL, 1'b1, gaps);
    checkFrames(FL);
    checkOutput("int_after_b", 32'(INT), 32'h1);
    applyStimulus(1'b1, FLAG, 16'h0000, rd);

    $display("[TB] B committed ahead of A");
    fillBuf(1'b1, 1'b0);
    applyStimulus(1'b1, FLAG, 16'h0100, rd);
    repeat (10) @(negedge Clk);
    checkOutput("b_waits_for_a", 32'(TX_VALID), 32'h0);
    applyStimulus(1'b0, FLAG, 16'h0, rd);
    checkOutput("flag_b_only_full", 32'(rd), 32'h0120);
    fillBuf(1'b0, 1'b0);
    applyStimulus(1'b1, FLAG, 16'h0080, rd);
    exp_q.delete();
    expectBuf(1'b0);
    expectBuf(1'b1);
    drain(2 * FL, 1'b0, gaps);
    checkFrames(2 * FL);
    checkOutput("gap_between_frames", 32'(gaps), 32'd1);

    $display("[TB] reset in the middle of a frame");
    fillBuf(1'b0, 1'b0);
    applyStimulus(1'b1, FLAG, 16'h0080, rd);
    drain(100, 1'b1, gaps);
    Rst = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(TX_VALID), 32'h0);
    checkOutput("midrst_last", 32'(TX_LAST), 32'h0);
    checkOutput("midrst_data", 32'(TX_DATA), 32'h0);
    checkOutput("midrst_int", 32'(INT), 32'h0);
    checkOutput("midrst_prdata", 32'(PRDATA), 32'h0);
    checkOutput("midrst_pready", 32'(PREADY), 32'h1);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    applyStimulus(1'b0, FLAG, 16'h0, rd);
    checkOutput("flag_after_midrst", 32'(rd), 32'h0060);
    applyStimulus(1'b0, BA + 32'd17, 16'h0, rd);
    checkOutput("a_kept_after_rst", 32'(rd), {24'h0, mem_a[17]});
    repeat (5) @(negedge Clk);
    checkOutput("idle_after_rst", 32'(TX_VALID), 32'h0);

    applyStimulus(1'b1, FLAG, 16'h0080, rd);
    exp_q.delete();
    expectBuf(1'b0);
    drain(FL, 1'b1, gaps);
    checkFrames(FL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
